rx_fifo_module: RTL

Receive-side byte buffer that sits directly downstream of the UART receive control stage. It captures each completed frame on the one-cycle done strobe and screens it against the parity and stop-bit error flags. Good bytes are queued in a synchronous FIFO for the application read port, and parity errors, frame errors and overflows are counted and reported. It also drives the receiver's enable.

---
 rtl/rx_fifo_module_if.sv | 43 ++++
 rtl/rx_fifo_module.sv | 125 ++++++++++++
 2 files changed

// File: rtl/rx_fifo_module_if.sv
// rx_fifo_module_if
//   Groups every non-clock, non-reset signal of the receive byte buffer.
//   slave  : the buffer's own view (rx_fifo_module).
//   master : the view of the surrounding logic (UART rx stage + application).
//   Signals:
//     enable / rx_en_sig                     receive enable request and its registered copy
//     rx_done_sig, rx_data,
//     dataerror, frameerror                  one-cycle frame-complete strobe and its payload
//     rd_en / rd_data, rd_valid              application read port
//     empty, full, level, overflow           FIFO status
//     parity_err_cnt, frame_err_cnt, clr_err error statistics and their clear
interface rx_fifo_module_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  enable;
    logic                  rx_en_sig;
    logic                  rx_done_sig;
    logic [7:0]            rx_data;
    logic                  dataerror;
    logic                  frameerror;
    logic                  rd_en;
    logic [7:0]            rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic [7:0]            parity_err_cnt;
    logic [7:0]            frame_err_cnt;
    logic                  clr_err;

    modport slave (
        input  enable, rx_done_sig, rx_data, dataerror, frameerror, rd_en, clr_err,
        output rx_en_sig, rd_data, rd_valid, empty, full, level, overflow,
               parity_err_cnt, frame_err_cnt
    );

    modport master (
        output enable, rx_done_sig, rx_data, dataerror, frameerror, rd_en, clr_err,
        input  rx_en_sig, rd_data, rd_valid, empty, full, level, overflow,
               parity_err_cnt, frame_err_cnt
    );
endinterface

// File: rtl/rx_fifo_module.sv
// rx_fifo_module
//   Receive-side byte buffer behind the UART receive control stage. Each
//   rx_done_sig strobe is one byte event: good bytes (and, when
//   DROP_ON_ERROR=0, errored ones too) are queued in a 2**DEPTH_LOG2 x 8
//   FIFO; parity/frame errors are counted with saturation, and a good byte
//   that finds the FIFO full sets a sticky overflow flag.
//   Ports:
//     sysclk  in  system clock, rising edge
//     rst_n   in  asynchronous active-low reset
//     bus     rx_fifo_module_if.slave (see interface header for signals)
module rx_fifo_module #(
    parameter int DEPTH_LOG2    = 4,
    parameter bit DROP_ON_ERROR = 1'b1
) (
    input  logic            sysclk,
    input  logic            rst_n,
    rx_fifo_module_if.slave bus
);
    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    // Storage has no reset so it can map onto block/distributed RAM.
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_overflow;
    logic [7:0]            r_rd_data;
    logic                  r_rd_valid;
    logic                  r_rx_en;

    logic                  w_good;
    logic                  w_rd_acc;
    logic                  w_wr;
    logic                  w_ovf_set;
    logic [DEPTH_LOG2:0]   w_level_next;
    logic [1:0]            w_err_flag;
    logic [7:0]            w_err_cnt [2];

    assign w_good   = !(bus.dataerror || bus.frameerror);
    assign w_rd_acc = bus.rd_en && !r_empty;
    // A read in the same cycle frees the slot, so a write at full is allowed then.
    assign w_wr      = bus.rx_done_sig && (w_good || !DROP_ON_ERROR) && (!r_full || w_rd_acc);
    assign w_ovf_set = bus.rx_done_sig && w_good && r_full && !w_rd_acc;

    always_comb begin
        w_level_next = r_level;
        case ({w_wr, w_rd_acc})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_rx_en    <= 1'b0;
        end else begin
            r_rx_en    <= bus.enable;
            r_level    <= w_level_next;
            // Flags are registered from the next level so they stay aligned with it.
            r_empty    <= (w_level_next == '0);
            r_full     <= (w_level_next == LEVEL_FULL);
            r_rd_valid <= w_rd_acc;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            // Clear wins over a same-cycle overflow event.
            if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end else if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Index 0 counts parity errors, index 1 counts frame errors.
    assign w_err_flag = {bus.frameerror, bus.dataerror};

    for (genvar gi = 0; gi < 2; gi++) begin : g_err_cnt
        logic [7:0] r_cnt;

        always_ff @(posedge sysclk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= 8'h00;
            end else if (bus.clr_err) begin
                r_cnt <= 8'h00;
            end else if (bus.rx_done_sig && w_err_flag[gi] && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end

        assign w_err_cnt[gi] = r_cnt;
    end

    assign bus.rx_en_sig      = r_rx_en;
    assign bus.rd_data        = r_rd_data;
    assign bus.rd_valid       = r_rd_valid;
    assign bus.empty          = r_empty;
    assign bus.full           = r_full;
    assign bus.level          = r_level;
    assign bus.overflow       = r_overflow;
    assign bus.parity_err_cnt = w_err_cnt[0];
    assign bus.frame_err_cnt  = w_err_cnt[1];
endmodule
